mmio_interconnect: RTL and testbench

//   Parametrised single-master, N-slave memory-mapped interconnect between the CPU data port and peripherals
//   (data memory, timer, UART, future blocks). Decodes the address against per-slave base/mask windows.

---
 rtl/mmio_interconnect_if.sv | 40 ++++
 rtl/mmio_interconnect.sv | 174 +++++++++++++++++
 tb/tb_mmio_interconnect.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_interconnect_if.sv
// CPU-side and peripheral-side signals of the MMIO interconnect.
// The interconnect uses modport slave; the environment (CPU plus peripherals) uses modport master.
interface mmio_interconnect_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                             m_req;
  logic                             m_we;
  logic [ADDR_WIDTH-1:0]            m_addr;
  logic [DATA_WIDTH-1:0]            m_wdata;
  logic [BE_W-1:0]                  m_be;
  logic                             m_ready;
  logic [DATA_WIDTH-1:0]            m_rdata;
  logic                             m_err;

  logic [NUM_SLAVES-1:0]            s_req;
  logic                             s_we;
  logic [ADDR_WIDTH-1:0]            s_addr;
  logic [DATA_WIDTH-1:0]            s_wdata;
  logic [BE_W-1:0]                  s_be;
  logic [NUM_SLAVES-1:0]            s_ack;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_ready, m_rdata, m_err,
    output s_req, s_we, s_addr, s_wdata, s_be,
    input  s_ack, s_rdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_ready, m_rdata, m_err,
    input  s_req, s_we, s_addr, s_wdata, s_be,
    output s_ack, s_rdata
  );
endinterface

// File: rtl/mmio_interconnect.sv
// Single-master, N-slave memory-mapped interconnect: base/mask decode, req/ack handshake
// with wait states and timeout, registered response, and error diagnostics.
module mmio_interconnect #(
  parameter int unsigned                        NUM_SLAVES     = 4,
  parameter int unsigned                        ADDR_WIDTH     = 32,
  parameter int unsigned                        DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]   SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]   SLAVE_MASK     = '0,
  parameter int unsigned                        TIMEOUT_CYCLES = 255,
  parameter int unsigned                        TO_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_interconnect_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [7:0]            err_count
);
  localparam int unsigned       BE_W    = DATA_WIDTH / 8;
  localparam int unsigned       IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]            state, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [NUM_SLAVES-1:0] s_req_q, s_req_d;
  logic                  m_ready_q, m_ready_d;
  logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
  logic                  m_err_q, m_err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  ack_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;

  // Address decode: first (lowest-index) matching window wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((bus.m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                   SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Only the latched slave's ack and read data are visible to the FSM.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ack_sel   = bus.s_ack[i];
        rdata_sel = bus.s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      s_req_q     <= '0;
      m_ready_q   <= 1'b0;
      m_rdata_q   <= '0;
      m_err_q     <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state       <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      s_req_q     <= s_req_d;
      m_ready_q   <= m_ready_d;
      m_rdata_q   <= m_rdata_d;
      m_err_q     <= m_err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state and next-output logic; m_ready is set on the edge that enters RESP.
  always_comb begin
    state_d     = state;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    s_req_d     = s_req_q;
    m_ready_d   = 1'b0;
    m_rdata_d   = m_rdata_q;
    m_err_d     = m_err_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    case (state)
      ST_IDLE: begin
        if (bus.m_req) begin
          we_d    = bus.m_we;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          be_d    = bus.m_be;
          if (hit) begin
            idx_d   = hit_idx;
            cnt_d   = '0;
            s_req_d = NUM_SLAVES'(1) << hit_idx;
            state_d = ST_ACCESS;
          end else begin
            m_ready_d  = 1'b1;
            m_err_d    = 1'b1;
            m_rdata_d  = '0;
            err_addr_d = bus.m_addr;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (ack_sel) begin
          s_req_d   = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b0;
          m_rdata_d = we_q ? '0 : rdata_sel;
          state_d   = ST_RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          s_req_d    = '0;
          m_ready_d  = 1'b1;
          m_err_d    = 1'b1;
          m_rdata_d  = '0;
          err_addr_d = addr_q;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.s_req   = s_req_q;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.s_be    = be_q;
  assign bus.m_ready = m_ready_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_err   = m_err_q;
  assign err_addr    = err_addr_q;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_mmio_interconnect.sv
// Self-checking bench for mmio_interconnect: vector table, random traffic against a
// decode/latency reference model, timeout, error saturation and mid-access reset.
module tb_mmio_interconnect;
  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          TO = 8;
  localparam logic [NS*AW-1:0] BASES = {32'h0000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASKS = {32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] err_addr, err_addr4;
  logic [7:0]    err_count, err_count4;

  mmio_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mmio_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();

  mmio_interconnect #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_BASE(BASES),
                      .SLAVE_MASK(MASKS), .TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .err_addr(err_addr), .err_count(err_count));

  mmio_interconnect #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_BASE(BASES),
                      .SLAVE_MASK(MASKS), .TIMEOUT_CYCLES(4), .TO_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .err_addr(err_addr4), .err_count(err_count4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference address map, written out independently of the packed DUT parameters.
  logic [31:0] ref_base [NS] = '{32'h0000_0000, 32'h0200_0000, 32'h1000_0000, 32'h0000_0000};
  logic [31:0] ref_mask [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_0000};
  int          m_cnt = 0;
  logic [31:0] m_eaddr = '0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    bit          spur;
    logic [31:0] rd;
    int          eidx;
    int          elat;
    logic        eerr;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & ref_mask[i]) == ref_base[i]) return i;
    return -1;
  endfunction

  // One transaction on the main DUT; waits<0 means the slave never acks.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int waits, input bit spur,
                         input logic [31:0] rd, input int eidx, input int elat, input logic eerr);
    logic [NS*DW-1:0] rbus;
    logic [NS-1:0]    eoh, ack;
    int               spur_idx, sreq_n, lat, esreq;
    bit               got, onehot_ok, stable_ok;
    logic             gerr;
    logic [31:0]      grd, erd;
    for (int i = 0; i < NS; i++) rbus[i*DW +: DW] = $urandom;
    if (eidx >= 0) rbus[eidx*DW +: DW] = rd;
    eoh      = (eidx >= 0) ? (NS'(1) << eidx) : '0;
    spur_idx = (eidx >= 0) ? (eidx + 1) % NS : 3;
    esreq    = (eidx >= 0) ? elat - 1 : 0;
    erd      = (eerr || we) ? 32'h0 : rd;
    got = 0; onehot_ok = 1; stable_ok = 1; sreq_n = 0; lat = 0; gerr = 1'b0; grd = '0;

    @(negedge clk);
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_be    = be;
    bus.s_rdata = rbus;
    bus.s_ack   = spur ? (NS'(1) << spur_idx) : '0;
    for (int c = 1; c <= TO + 20 && !got; c++) begin
      @(negedge clk);
      bus.m_req   = 1'b0;
      bus.m_we    = ~we;
      bus.m_addr  = $urandom;
      bus.m_wdata = $urandom;
      if (bus.m_ready) begin
        got = 1; lat = c; gerr = bus.m_err; grd = bus.m_rdata;
      end
      if (bus.s_req != '0) begin
        sreq_n++;
        if (bus.s_req !== eoh) onehot_ok = 0;
        if (bus.s_addr !== addr || bus.s_we !== we || bus.s_wdata !== wdata || bus.s_be !== be)
          stable_ok = 0;
      end
      ack = spur ? (NS'(1) << spur_idx) : '0;
      if (eidx >= 0 && waits >= 0 && bus.s_req[eidx] && sreq_n == waits + 1) ack[eidx] = 1'b1;
      bus.s_ack = ack;
    end
    check("ready_seen", 64'(got), 64'd1);
    check("latency", 64'(lat), 64'(elat));
    check("m_err", 64'(gerr), 64'(eerr));
    check("m_rdata", 64'(grd), 64'(erd));
    check("s_req_cycles", 64'(sreq_n), 64'(esreq));
    check("s_req_onehot", 64'(onehot_ok), 64'd1);
    check("s_fields_stable", 64'(stable_ok), 64'd1);
    if (eerr) begin
      if (m_cnt < 255) m_cnt++;
      m_eaddr = addr;
    end
    @(negedge clk);
    bus.s_ack = '0;
    check("ready_pulse_width", 64'(bus.m_ready), 64'd0);
    check("err_count", 64'(err_count), 64'(m_cnt));
    check("err_addr", 64'(err_addr), 64'(m_eaddr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          eidx, elat, w, sel, n, lat;
    logic        eerr, gerr;
    logic [31:0] a;
    bit          got;

    vt[0] = '{1'b0, 32'h0200_0004, 32'h0,         4'hF, 0,  1'b0, 32'hDEAD_BEEF,  1, 2, 1'b0};
    vt[1] = '{1'b1, 32'h1000_0000, 32'h41,        4'h1, 5,  1'b0, 32'hCAFE_F00D,  2, 7, 1'b0};
    vt[2] = '{1'b0, 32'h7F00_0000, 32'h0,         4'hF, 0,  1'b0, 32'h0,         -1, 1, 1'b1};
    vt[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 2,  1'b0, 32'h1357_9BDF,  0, 4, 1'b0};
    vt[4] = '{1'b0, 32'h0200_0100, 32'h0,         4'hF, 1,  1'b1, 32'hA5A5_5A5A,  1, 3, 1'b0};
    vt[5] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, -1, 1'b0, 32'h0,          0, 9, 1'b1};
    vt[6] = '{1'b0, 32'h1000_0040, 32'h0,         4'hF, 7,  1'b0, 32'h0BAD_F00D,  2, 9, 1'b0};
    vt[7] = '{1'b1, 32'h0200_0008, 32'h1234_5678, 4'h6, 3,  1'b1, 32'hFFFF_FFFF,  1, 5, 1'b0};

    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_be = '0;
    bus.s_ack = '0; bus.s_rdata = '0;
    bus4.m_req = 1'b0; bus4.m_we = 1'b0; bus4.m_addr = '0; bus4.m_wdata = '0; bus4.m_be = '0;
    bus4.s_ack = '0; bus4.s_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_m_ready", 64'(bus.m_ready), 64'd0);
    check("rst_s_req", 64'(bus.s_req), 64'd0);
    check("rst_s_addr", 64'(bus.s_addr), 64'd0);
    check("rst_m_rdata", 64'(bus.m_rdata), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_s_req", 64'(bus.s_req), 64'd0);
    check("idle_err_addr", 64'(err_addr), 64'd0);

    // Timeout of 4 on the second instance: slave 0 never acks.
    bus4.m_req = 1'b1; bus4.m_addr = 32'h0000_0100;
    got = 0; n = 0; lat = 0; gerr = 1'b0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      bus4.m_req = 1'b0;
      if (bus4.m_ready) begin got = 1; lat = c; gerr = bus4.m_err; end
      if (bus4.s_req[0]) n++;
    end
    check("to4_latency", 64'(lat), 64'd5);
    check("to4_s_req_cycles", 64'(n), 64'd4);
    check("to4_m_err", 64'(gerr), 64'd1);
    check("to4_err_count", 64'(err_count4), 64'd1);
    check("to4_err_addr", 64'(err_addr4), 64'h0000_0100);

    for (int i = 0; i < 8; i++)
      run_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].waits, vt[i].spur,
              vt[i].rd, vt[i].eidx, vt[i].elat, vt[i].eerr);

    // Random traffic against the reference decode/latency rules.
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       a = $urandom & 32'h00FF_FFFF;
        1:       a = 32'h0200_0000 | ($urandom & 32'h00FF_FFFF);
        2:       a = 32'h1000_0000 | ($urandom & 32'h00FF_FFFF);
        default: a = $urandom;
      endcase
      w    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 9));
      eidx = ref_decode(a);
      if (eidx < 0) begin
        elat = 1; eerr = 1'b1;
      end else if (w >= 0 && w < TO) begin
        elat = w + 2; eerr = 1'b0;
      end else begin
        elat = TO + 1; eerr = 1'b1;
      end
      run_txn(1'($urandom), a, $urandom, 4'($urandom), w, 1'($urandom_range(0, 1)),
              $urandom, eidx, elat, eerr);
    end

    // Drive the error counter into saturation with unmapped reads.
    for (int k = 0; k < 256; k++)
      run_txn(1'b0, 32'h7E00_0000 | 32'(k), 32'h0, 4'hF, 0, 1'b0, 32'h0, -1, 1, 1'b1);
    check("err_count_saturated", 64'(err_count), 64'hFF);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h0200_0010; bus.s_ack = '0;
    @(negedge clk);
    bus.m_req = 1'b0;
    check("pre_rst_s_req", 64'(bus.s_req), 64'h2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_s_req", 64'(bus.s_req), 64'd0);
    check("async_rst_m_ready", 64'(bus.m_ready), 64'd0);
    check("async_rst_err_count", 64'(err_count), 64'd0);
    check("async_rst_err_addr", 64'(err_addr), 64'd0);
    check("async_rst_s_addr", 64'(bus.s_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    m_cnt = 0; m_eaddr = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_ready", 64'(bus.m_ready), 64'd0);
    end
    run_txn(1'b0, 32'h0200_0020, 32'h0, 4'hF, 0, 1'b0, 32'h1234_5678, 1, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
